// File: rtl/uart2wifi_core_cmd_bridge_pkg.sv
// uart2wifi_pkg: state encoding and byte constants for the command bridge.
// The ACK state exists only when UART2WIFI_CMD_ACK_EN is defined.
package uart2wifi_pkg;
    typedef enum logic [2:0] {
        IDLE,
        WDATA,
        WRITE,
        READ,
        RCAPT,
        RESP
`ifdef UART2WIFI_CMD_ACK_EN
        , ACK
`endif
    } cmd_state_t;
    localparam int         CMD_WRITE_BIT  = 7;
    localparam logic [7:0] ACK_BYTE       = 8'h06;
    localparam logic [7:0] NAK_BYTE       = 8'h15;
    localparam int         REG_DATA_BYTES = 4;
endpackage

// File: rtl/uart2wifi_core_cmd_bridge.sv
// uart2wifi_core_cmd_bridge: decodes RX FIFO command bytes into register writes/reads and returns read data LSB first.
// Define UART2WIFI_CMD_ACK_EN to push ACK_BYTE after writes and NAK_BYTE after rejected commands.
module uart2wifi_core_cmd_bridge
    import uart2wifi_pkg::*;
#(
    parameter int ADDR_W   = 2,
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_empty,
    input  logic [7:0]        rx_data,
    output logic              rx_rd,
    input  logic              tx_full,
    output logic [7:0]        tx_data,
    output logic              tx_wr,
    output logic [ADDR_W-1:0] reg_addr,
    output logic [DATA_W-1:0] reg_wdata,
    output logic              reg_write,
    output logic              reg_read,
    input  logic [DATA_W-1:0] reg_rdata,
    output logic              busy,
    output logic              cmd_err
);
    localparam logic [1:0]      LAST_BYTE  = 2'(REG_DATA_BYTES - 1);
    localparam logic [ADDR_W:0] NUM_REGS_W = NUM_REGS[ADDR_W:0];

    cmd_state_t        r_state;
    logic [1:0]        r_cnt;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_rsp;
    logic              r_cmd_err;
    logic              w_valid;
`ifdef UART2WIFI_CMD_ACK_EN
    logic [7:0]        r_ack;
`endif

    assign w_valid   = !(|rx_data[6:ADDR_W]) && ({1'b0, rx_data[ADDR_W-1:0]} < NUM_REGS_W);
    assign rx_rd     = (r_state == IDLE || r_state == WDATA) && !rx_empty;
    assign reg_addr  = r_addr;
    assign reg_wdata = r_wdata;
    assign reg_write = r_state == WRITE;
    assign reg_read  = r_state == READ;
    assign busy      = r_state != IDLE;
    assign cmd_err   = r_cmd_err;
`ifdef UART2WIFI_CMD_ACK_EN
    assign tx_data   = r_state == RESP ? r_rsp[7:0] : r_state == ACK ? r_ack : 8'h00;
    assign tx_wr     = (r_state == RESP || r_state == ACK) && !tx_full;
`else
    assign tx_data   = r_state == RESP ? r_rsp[7:0] : 8'h00;
    assign tx_wr     = r_state == RESP && !tx_full;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_rsp     <= '0;
            r_cmd_err <= 1'b0;
`ifdef UART2WIFI_CMD_ACK_EN
            r_ack     <= '0;
`endif
        end else begin
            r_cmd_err <= 1'b0;
            case (r_state)
                IDLE: if (!rx_empty) begin
                    if (!w_valid) begin
                        r_cmd_err <= 1'b1;
`ifdef UART2WIFI_CMD_ACK_EN
                        r_ack     <= NAK_BYTE;
                        r_state   <= ACK;
`endif
                    end else begin
                        r_addr  <= rx_data[ADDR_W-1:0];
                        r_cnt   <= '0;
                        r_state <= rx_data[CMD_WRITE_BIT] ? WDATA : READ;
                    end
                end
                WDATA: if (!rx_empty) begin
                    r_wdata[{r_cnt, 3'b000} +: 8] <= rx_data;
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == LAST_BYTE) r_state <= WRITE;
                end
`ifdef UART2WIFI_CMD_ACK_EN
                WRITE: begin
                    r_ack   <= ACK_BYTE;
                    r_state <= ACK;
                end
                ACK: if (!tx_full) r_state <= IDLE;
`else
                WRITE: r_state <= IDLE;
`endif
                READ: r_state <= RCAPT;
                RCAPT: begin
                    r_rsp   <= reg_rdata;
                    r_cnt   <= '0;
                    r_state <= RESP;
                end
                RESP: if (!tx_full) begin
                    r_rsp <= r_rsp >> 8;
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == LAST_BYTE) r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart2wifi_core_cmd_bridge.sv
// tb_uart2wifi_core_cmd_bridge: vector table of commands plus stall, gap and mid-frame reset sequences.
// Expected TX traffic follows UART2WIFI_CMD_ACK_EN.
module tb_uart2wifi_core_cmd_bridge;
    localparam int K_WR = 0, K_RD = 1, K_RJ = 2;
`ifdef UART2WIFI_CMD_ACK_EN
    localparam bit ACK_ON = 1'b1;
`else
    localparam bit ACK_ON = 1'b0;
`endif

    typedef struct {
        logic [7:0]  cmd;
        logic [31:0] seq;
        int          kind;
        logic [1:0]  addr;
        logic [31:0] word;
    } vec_t;

    logic        clk = 1'b0, rst = 1'b1;
    logic        rx_empty = 1'b1, tx_full = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic [31:0] reg_rdata = 32'h0;
    logic        rx_rd, tx_wr, reg_write, reg_read, busy, cmd_err;
    logic [7:0]  tx_data;
    logic [1:0]  reg_addr;
    logic [31:0] reg_wdata;

    uart2wifi_core_cmd_bridge dut (
        .clk(clk), .rst(rst), .rx_empty(rx_empty), .rx_data(rx_data), .rx_rd(rx_rd),
        .tx_full(tx_full), .tx_data(tx_data), .tx_wr(tx_wr), .reg_addr(reg_addr),
        .reg_wdata(reg_wdata), .reg_write(reg_write), .reg_read(reg_read),
        .reg_rdata(reg_rdata), .busy(busy), .cmd_err(cmd_err)
    );

    always #10 clk = ~clk;

    int checks = 0, errors = 0;
    logic [7:0]  rxq[$];
    logic [7:0]  txq[$];
    logic [31:0] regs [3];
    int cyc = 0, n_wr = 0, n_rd = 0, n_err = 0, n_both = 0;
    int pop_cyc = 0, wr_cyc = 0, rd_cyc = 0, tx_first = 0, tx_last = 0;
    logic [1:0]  wr_addr = 2'd0;
    logic [31:0] wr_data = 32'h0;

    // FIFO and register-block models plus event recorders
    initial begin
        logic        rd_seen;
        logic [31:0] rd_val;
        for (int i = 0; i < 3; i++) regs[i] = 32'h0;
        forever begin
            @(posedge clk);
            cyc++;
            rd_seen = 1'b0;
            rd_val  = 32'h0;
            if (rx_rd) begin
                if (rxq.size() != 0) void'(rxq.pop_front());
                pop_cyc = cyc;
            end
            if (tx_wr) begin
                if (txq.size() == 0) tx_first = cyc;
                txq.push_back(tx_data);
                tx_last = cyc;
            end
            if (reg_write) begin
                n_wr++;
                wr_cyc  = cyc;
                wr_addr = reg_addr;
                wr_data = reg_wdata;
                if (reg_addr < 2'd3) regs[reg_addr] = reg_wdata;
            end
            if (reg_read) begin
                n_rd++;
                rd_cyc  = cyc;
                rd_seen = 1'b1;
                rd_val  = reg_addr < 2'd3 ? regs[reg_addr] : 32'h0;
            end
            if (reg_write && reg_read) n_both++;
            if (cmd_err) n_err++;
            #1;
            rx_empty = rxq.size() == 0;
            rx_data  = rx_empty ? 8'h00 : rxq[0];
            if (rd_seen) reg_rdata = rd_val;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] tx_word();
        logic [31:0] w = 32'h0;
        for (int k = 0; k < txq.size() && k < 4; k++) w[8*k +: 8] = txq[k];
        return w;
    endfunction

    task automatic wait_idle(input string name);
        int n = 0;
        while ((rxq.size() != 0 || busy) && n < 300) begin
            @(negedge clk);
            n++;
        end
        check({name, "_timeout"}, 64'(n < 300), 64'd1);
        repeat (3) @(negedge clk);
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while (rxq.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check({name, "_drain"}, 64'(n < 50), 64'd1);
    endtask

    task automatic run_vec(input vec_t v, input string nm);
        int          wr0, rd0, er0, ntx;
        logic [31:0] etx;
        wr0 = n_wr;
        rd0 = n_rd;
        er0 = n_err;
        txq.delete();
        @(negedge clk);
        rxq.push_back(v.cmd);
        if (v.kind == K_WR) for (int b = 3; b >= 0; b--) rxq.push_back(v.seq[8*b +: 8]);
        wait_idle(nm);
        ntx = v.kind == K_RD ? 4 : (ACK_ON ? 1 : 0);
        etx = v.kind == K_RD ? v.word : v.kind == K_WR ? 32'h06 : 32'h15;
        if (ntx == 0) etx = 32'h0;
        check({nm, "_writes"}, 64'(n_wr - wr0), 64'(v.kind == K_WR));
        check({nm, "_reads"}, 64'(n_rd - rd0), 64'(v.kind == K_RD));
        check({nm, "_errs"}, 64'(n_err - er0), 64'(v.kind == K_RJ));
        check({nm, "_txcount"}, 64'(txq.size()), 64'(ntx));
        check({nm, "_txbytes"}, 64'(tx_word()), 64'(etx));
        if (v.kind == K_WR) begin
            check({nm, "_waddr"}, 64'(wr_addr), 64'(v.addr));
            check({nm, "_wdata"}, 64'(wr_data), 64'(v.word));
            check({nm, "_wlat"}, 64'(wr_cyc - pop_cyc), 64'd1);
        end
        if (v.kind == K_RD) begin
            check({nm, "_rlat"}, 64'(rd_cyc - pop_cyc), 64'd1);
            check({nm, "_tx_first"}, 64'(tx_first - pop_cyc), 64'd3);
            check({nm, "_tx_last"}, 64'(tx_last - pop_cyc), 64'd6);
        end
    endtask

    initial begin
        vec_t vecs[11];
        vec_t rv;
        int   wr0, rd0;
        vecs[0]  = '{8'h81, 32'hDEADBEEF, K_WR, 2'd1, 32'hEFBEADDE};
        vecs[1]  = '{8'h01, 32'h0,        K_RD, 2'd1, 32'hEFBEADDE};
        vecs[2]  = '{8'h03, 32'h0,        K_RJ, 2'd0, 32'h0};
        vecs[3]  = '{8'h44, 32'h0,        K_RJ, 2'd0, 32'h0};
        vecs[4]  = '{8'h80, 32'h78563412, K_WR, 2'd0, 32'h12345678};
        vecs[5]  = '{8'h82, 32'h5A5AA5A5, K_WR, 2'd2, 32'hA5A55A5A};
        vecs[6]  = '{8'h00, 32'h0,        K_RD, 2'd0, 32'h12345678};
        vecs[7]  = '{8'h02, 32'h0,        K_RD, 2'd2, 32'hA5A55A5A};
        vecs[8]  = '{8'hFF, 32'h0,        K_RJ, 2'd0, 32'h0};
        vecs[9]  = '{8'h7E, 32'h0,        K_RJ, 2'd0, 32'h0};
        vecs[10] = '{8'h01, 32'h0,        K_RD, 2'd1, 32'hEFBEADDE};

        repeat (3) @(negedge clk);
        check("reset_outputs", 64'({rx_rd, tx_wr, tx_data, reg_addr, reg_wdata, reg_write, reg_read, busy, cmd_err}), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 11; i++) run_vec(vecs[i], $sformatf("v%0d", i));

        // read response held off by a full TX FIFO
        rd0 = n_rd;
        txq.delete();
        tx_full = 1'b1;
        rxq.push_back(8'h01);
        repeat (20) @(negedge clk);
        check("stall_no_tx", 64'(txq.size()), 64'd0);
        check("stall_busy", 64'(busy), 64'd1);
        check("stall_one_read", 64'(n_rd - rd0), 64'd1);
        tx_full = 1'b0;
        wait_idle("stall");
        check("stall_txcount", 64'(txq.size()), 64'd4);
        check("stall_txbytes", 64'(tx_word()), 64'hEFBEADDE);

        // write with 10-cycle empty gaps between data bytes
        wr0 = n_wr;
        rxq.push_back(8'h82);
        wait_drain("gap_cmd");
        for (int b = 0; b < 4; b++) begin
            logic [31:0] pay = 32'hCAFEF00D;
            repeat (10) @(negedge clk);
            rxq.push_back(pay[8*b +: 8]);
            wait_drain($sformatf("gap_b%0d", b));
        end
        wait_idle("gap");
        check("gap_writes", 64'(n_wr - wr0), 64'd1);
        check("gap_waddr", 64'(wr_addr), 64'd2);
        check("gap_wdata", 64'(wr_data), 64'hCAFEF00D);

        // reset after two of four data bytes
        wr0 = n_wr;
        rxq.push_back(8'h81);
        rxq.push_back(8'h11);
        rxq.push_back(8'h22);
        wait_drain("rst_mid");
        repeat (2) @(negedge clk);
        check("rst_mid_busy_before", 64'(busy), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_mid_idle", 64'({busy, reg_write, reg_wdata}), 64'd0);
        rv = '{8'h01, 32'h0, K_RD, 2'd1, 32'hEFBEADDE};
        run_vec(rv, "rst_read");
        check("rst_no_write", 64'(n_wr - wr0), 64'd0);

        check("strobe_exclusive", 64'(n_both), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
